// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage with a handshaked memory port.
//
// Sends loads and stores from EX_MEM to a memory or peripheral port that
// may insert wait states. While an access is waiting, the stage stalls the
// front of the pipe and puts bubbles into MEM/WB. If an access gets no
// acknowledge within TIMEOUT request cycles, the stage aborts it for one
// cycle, sets the sticky mem_err flag and lets the instruction retire.
// An aborted load does not write to the register file.
//
// Ports
//   clk, rst                       clock, async active-high reset
//   we_in, dst_addr_in, alu_in     register writeback fields from EX_MEM
//   Mem_re_in, Mem_we_in           load / store request (store wins)
//   Mem_sel_in, d_addr_in,         target select, address, store data
//   wrt_data_in
//   mem_req, mem_wr, mem_sel,      memory request side (combinational)
//   mem_addr, mem_wdata
//   mem_ack, mem_rdata             memory response (data valid with ack)
//   stall                          hold EX_MEM and all earlier stages
//   wb_we, wb_dst_addr, wb_data    registered MEM/WB bundle
//   mem_err                        sticky timeout flag, cleared by rst only
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_in,
  input  logic [3:0]  dst_addr_in,
  input  logic [15:0] alu_in,
  input  logic        Mem_re_in,
  input  logic        Mem_we_in,
  input  logic        Mem_sel_in,
  input  logic [15:0] d_addr_in,
  input  logic [15:0] wrt_data_in,
  output logic        mem_req,
  output logic        mem_wr,
  output logic        mem_sel,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        stall,
  output logic        wb_we,
  output logic [3:0]  wb_dst_addr,
  output logic [15:0] wb_data,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       access, is_load;

  assign access    = Mem_re_in | Mem_we_in;
  // A store wins when both requests are set, so no read happens.
  assign is_load   = Mem_re_in & ~Mem_we_in;
  assign mem_wr    = Mem_we_in;
  assign mem_sel   = Mem_sel_in;
  assign mem_addr  = d_addr_in;
  assign mem_wdata = wrt_data_in;

  // wait_cnt holds the number of unacknowledged request cycles already
  // seen. The first of these happens in IDLE, so BUSY starts at 1. The
  // abort then happens after exactly TIMEOUT request cycles.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = 8'd0;
    mem_req      = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          mem_req = 1'b1;
          if (!mem_ack) begin
            state_nxt    = BUSY;
            wait_cnt_nxt = 8'd1;
          end
        end
      end
      BUSY: begin
        mem_req = 1'b1;
        if (mem_ack)                    state_nxt = IDLE;
        else if (wait_cnt == LAST_WAIT) state_nxt = ABORT;
        else                            wait_cnt_nxt = wait_cnt + 8'd1;
      end
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // In IDLE the state register is already at reset, but the access
    // inputs can still be live. Gate mem_req here so that reset silences
    // the port at once.
    if (rst) mem_req = 1'b0;
  end

  // mem_req is always low in ABORT, so stall is low there as well.
  // An ack that arrives while no request is outstanding has no effect.
  assign stall = mem_req & ~mem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we       <= 1'b0;
      wb_dst_addr <= 4'd0;
      wb_data     <= 16'd0;
      mem_err     <= 1'b0;
    end else if (stall) begin
      wb_we <= 1'b0;
    end else if (state == ABORT) begin
      mem_err     <= 1'b1;
      wb_we       <= we_in & ~is_load;
      wb_dst_addr <= dst_addr_in;
      wb_data     <= alu_in;
    end else begin
      wb_we       <= we_in;
      wb_dst_addr <= dst_addr_in;
      wb_data     <= is_load ? mem_rdata : alu_in;
    end
  end

endmodule
